// File: rtl/hermes_periph_mux.sv
`default_nettype none
// ============================================================================
// Module   : hermes_periph_mux
// Purpose  : Merges N_SRC credit-flow peripheral channels onto one Hermes NoC
//            boundary port. Each channel has its own FIFO, and packets are
//            granted atomically in round-robin order. Packet framing is
//            header, size S, then S payload flits.
// Options  : HERMES_PERIPH_MUX_STATS_EN - builds the per-channel counters of
//            completed packets. Without it, pkt_count_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hermes_periph_mux #(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N_SRC-1:0]                 src_rx_i,
    output logic [N_SRC-1:0]                 src_credit_o,
    input  logic [N_SRC-1:0][FLIT_SIZE-1:0]  src_data_i,
    output logic                             noc_tx_o,
    input  logic                             noc_credit_i,
    output logic [FLIT_SIZE-1:0]             noc_data_o,
    input  logic                             release_i,
    output logic [N_SRC-1:0]                 grant_o,
    output logic [N_SRC-1:0][15:0]           pkt_count_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    logic [N_SRC-1:0][FLIT_SIZE-1:0] head;
    logic [N_SRC-1:0]                not_empty;
    logic [N_SRC-1:0]                push;
    logic [N_SRC-1:0]                pop;

    state_t                 state_q, state_d;
    logic [N_SRC-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [FLIT_SIZE-1:0]   cnt_q, cnt_d;
    logic [FLIT_SIZE-1:0]   cur_head;
    logic                   cur_ne;
    logic                   xfer;
    logic                   pkt_done;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;

    // Per-channel circular FIFO. The pointers wrap naturally because BUF_DEPTH is a power of two.
    for (genvar i = 0; i < N_SRC; i++) begin : g_fifo
        logic [FLIT_SIZE-1:0] mem_q [BUF_DEPTH];
        logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]     count_q, count_d;

        assign src_credit_o[i] = (count_q != CNT_W'(BUF_DEPTH));
        assign push[i]         = src_rx_i[i] & src_credit_o[i];
        assign not_empty[i]    = (count_q != '0);
        assign head[i]         = mem_q[rd_ptr_q];

        // Advance the pointers and the occupancy; a push and a pop together leave the occupancy unchanged.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push[i]) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop[i])  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push[i], pop[i]})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Register the FIFO control state. Reset empties the FIFO at once.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Flit storage. Its contents are meaningless while the FIFO is empty, so it has no reset.
        always_ff @(posedge clk_i) begin
            if (push[i]) mem_q[wr_ptr_q] <= src_data_i[i];
        end
    end

    // Select the head flit of the granted channel. grant_q is one-hot or zero.
    always_comb begin
        cur_head = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) cur_head = cur_head | head[i];
        end
    end

    assign cur_ne     = |(grant_q & not_empty);
    assign noc_tx_o   = (state_q != IDLE) && cur_ne;
    assign xfer       = noc_tx_o & noc_credit_i;
    assign pop        = grant_q & {N_SRC{xfer}};
    assign noc_data_o = noc_tx_o ? cur_head : '0;
    assign grant_o    = grant_q;

    // Round-robin search for a non-empty channel, starting at the channel after the last grant.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_SRC);
            if (!win_found && not_empty[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Packet framing FSM. The channel is held from the header to the last flit, whatever release_i does.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        pkt_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (release_i && win_found) begin
                    state_d = HDR;
                    grant_d = N_SRC'(1) << win_idx;
                    last_d  = win_idx;
                end
            end
            HDR: begin
                if (xfer) state_d = SIZE;
            end
            SIZE: begin
                if (xfer) begin
                    cnt_d = cur_head;
                    if (cur_head == '0) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        pkt_done = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == FLIT_SIZE'(1)) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        pkt_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register the FSM state. Reset drops any partial packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HERMES_PERIPH_MUX_STATS_EN
    for (genvar i = 0; i < N_SRC; i++) begin : g_stats
        logic [15:0] pkt_cnt_q, pkt_cnt_d;

        // Count the packets this channel completes. The counter wraps at 16 bits.
        always_comb begin
            pkt_cnt_d = pkt_cnt_q;
            if (pkt_done && grant_q[i]) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end

        // Register the packet counter.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) pkt_cnt_q <= '0;
            else         pkt_cnt_q <= pkt_cnt_d;
        end

        assign pkt_count_o[i] = pkt_cnt_q;
    end
`else
    logic stats_unused;
    assign stats_unused = pkt_done;
    assign pkt_count_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hermes_periph_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_hermes_periph_mux
// Purpose  : Scoreboard bench for hermes_periph_mux. It applies random packet
//            traffic, credit stalls, release gating and a mid-packet reset.
//            It checks the DUT against a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hermes_periph_mux;

    localparam int N_SRC     = 3;
    localparam int FLIT_SIZE = 16;
    localparam int BUF_DEPTH = 4;

    logic                            clk_i = 1'b0;
    logic                            rst_ni = 1'b1;
    logic [N_SRC-1:0]                src_rx_i;
    logic [N_SRC-1:0]                src_credit_o;
    logic [N_SRC-1:0][FLIT_SIZE-1:0] src_data_i;
    logic                            noc_tx_o;
    logic                            noc_credit_i;
    logic [FLIT_SIZE-1:0]            noc_data_o;
    logic                            release_i;
    logic [N_SRC-1:0]                grant_o;
    logic [N_SRC-1:0][15:0]          pkt_count_o;

    hermes_periph_mux #(
        .N_SRC     (N_SRC),
        .FLIT_SIZE (FLIT_SIZE),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .src_rx_i     (src_rx_i),
        .src_credit_o (src_credit_o),
        .src_data_i   (src_data_i),
        .noc_tx_o     (noc_tx_o),
        .noc_credit_i (noc_credit_i),
        .noc_data_o   (noc_data_o),
        .release_i    (release_i),
        .grant_o      (grant_o),
        .pkt_count_o  (pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Flits each source still has to offer (driver side).
    logic [FLIT_SIZE-1:0] gen_q [N_SRC][$];
    // Scoreboard: flits accepted into each channel and not yet seen on the NoC.
    logic [FLIT_SIZE-1:0] exp_q [N_SRC][$];
    logic [N_SRC-1:0]     acc;

    // Packet-level reference state.
    bit               m_busy  = 1'b0;
    int               m_ch    = 0;
    int               m_phase = 0;   // 0 header, 1 size, 2 payload
    int               m_rem   = 0;
    int               m_last  = 0;
    int               m_cnt [N_SRC];
    logic [N_SRC-1:0] m_cr;
    logic [FLIT_SIZE-1:0] m_flit;
    int               m_c;
    bit               m_found;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N_SRC; i++) n += gen_q[i].size() + exp_q[i].size();
        return n + int'(m_busy);
    endfunction

    // Monitor: mid-cycle sample of everything the coming rising edge will act on.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            check("rst_tx", 64'(noc_tx_o), 64'd0);
            check("rst_grant", 64'(grant_o), 64'd0);
            check("rst_credit", 64'(src_credit_o), 64'({N_SRC{1'b1}}));
            check("rst_data", 64'(noc_data_o), 64'd0);
            for (int i = 0; i < N_SRC; i++) begin
                check("rst_pkt_count", 64'(pkt_count_o[i]), 64'd0);
                exp_q[i].delete();
                m_cnt[i] = 0;
            end
            m_busy = 1'b0;
            m_last = 0;
            acc    = '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                m_cr[i] = (exp_q[i].size() < BUF_DEPTH);
`ifdef HERMES_PERIPH_MUX_STATS_EN
                check("pkt_count", 64'(pkt_count_o[i]), 64'(m_cnt[i] % 65536));
`else
                check("pkt_count", 64'(pkt_count_o[i]), 64'd0);
`endif
            end
            check("credit", 64'(src_credit_o), 64'(m_cr));
            if (!m_busy) begin
                check("idle_tx", 64'(noc_tx_o), 64'd0);
                check("idle_grant", 64'(grant_o), 64'd0);
                if (release_i) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= N_SRC; k++) begin
                        m_c = (m_last + k) % N_SRC;
                        if (!m_found && exp_q[m_c].size() != 0) begin
                            m_found = 1'b1;
                            m_ch    = m_c;
                        end
                    end
                    if (m_found) begin
                        m_busy  = 1'b1;
                        m_phase = 0;
                        m_last  = m_ch;
                    end
                end
            end else begin
                check("grant", 64'(grant_o), 64'(1) << m_ch);
                check("tx", 64'(noc_tx_o), 64'(exp_q[m_ch].size() != 0));
                if (exp_q[m_ch].size() != 0) begin
                    check("data", 64'(noc_data_o), 64'(exp_q[m_ch][0]));
                    if (noc_credit_i) begin
                        m_flit = exp_q[m_ch].pop_front();
                        if (m_phase == 0) begin
                            m_phase = 1;
                        end else if (m_phase == 1) begin
                            m_rem   = int'(m_flit);
                            m_phase = 2;
                        end else begin
                            m_rem = m_rem - 1;
                        end
                        if (m_phase == 2 && m_rem == 0) begin
                            m_busy      = 1'b0;
                            m_cnt[m_ch] = m_cnt[m_ch] + 1;
                        end
                    end
                end
            end
            for (int i = 0; i < N_SRC; i++) begin
                acc[i] = src_rx_i[i] && m_cr[i];
                if (acc[i]) exp_q[i].push_back(src_data_i[i]);
            end
        end
    end

    task automatic add_packet(int ch, int s);
        gen_q[ch].push_back(FLIT_SIZE'($urandom));
        gen_q[ch].push_back(FLIT_SIZE'(s));
        for (int k = 0; k < s; k++) gen_q[ch].push_back(FLIT_SIZE'($urandom));
    endtask

    task automatic drive_cycle(int p_rx, int p_credit);
        @(posedge clk_i);
        #2;
        for (int i = 0; i < N_SRC; i++) begin
            if (acc[i] && gen_q[i].size() != 0) void'(gen_q[i].pop_front());
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (gen_q[i].size() != 0 && $urandom_range(99) < p_rx) begin
                src_rx_i[i]   = 1'b1;
                src_data_i[i] = gen_q[i][0];
            end else begin
                src_rx_i[i]   = 1'b0;
                src_data_i[i] = FLIT_SIZE'($urandom);
            end
        end
        noc_credit_i = ($urandom_range(99) < p_credit);
    endtask

    task automatic drain(string tag);
        int n = 0;
        release_i = 1'b1;
        while (pending() != 0 && n < 3000) begin
            drive_cycle(90, 80);
            n++;
        end
        if (pending() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_%s: %0d items still pending, expected 0", tag, pending());
        end
    endtask

    task automatic wait_payload(string tag, int p_credit);
        int n = 0;
        while (!(m_busy && m_phase == 2) && n < 500) begin
            drive_cycle(100, p_credit);
            n++;
        end
        if (!(m_busy && m_phase == 2)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_%s: payload phase not reached, got busy=%0d phase=%0d, expected 1/2", tag, m_busy, m_phase);
        end
    endtask

    initial begin
        src_rx_i     = '0;
        src_data_i   = '0;
        noc_credit_i = 1'b1;
        release_i    = 1'b0;
        acc          = '0;
        for (int i = 0; i < N_SRC; i++) m_cnt[i] = 0;
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Channel 0 loaded while release is low: nothing may start.
        gen_q[0].push_back(16'h0101);
        gen_q[0].push_back(16'd3);
        gen_q[0].push_back(16'h000A);
        gen_q[0].push_back(16'h000B);
        gen_q[0].push_back(16'h000C);
        repeat (15) drive_cycle(100, 100);
        drain("single");

        // Zero-size packet followed at once by another on the same channel, and both channels contending.
        add_packet(1, 0);
        add_packet(1, 2);
        add_packet(0, 1);
        drain("zero_size");

        // Credit stall mid-payload while the source keeps streaming.
        add_packet(0, 12);
        release_i = 1'b1;
        wait_payload("stall", 100);
        repeat (6) drive_cycle(100, 0);
        drain("stall");

        // release_i dropped mid-payload: the packet finishes, and the next one is held.
        add_packet(2, 8);
        add_packet(1, 2);
        wait_payload("release", 100);
        release_i = 1'b0;
        repeat (40) drive_cycle(100, 100);
        drain("release");

        // Random traffic with random release gating and back-pressure.
        for (int it = 0; it < 1500; it++) begin
            if (pending() < 14) add_packet($urandom_range(N_SRC - 1), $urandom_range(0, 6));
            release_i = ($urandom_range(99) < 85);
            drive_cycle(70, 75);
        end
        drain("random");

        // Reset pulse mid-payload: every remaining flit is discarded.
        add_packet(1, 9);
        add_packet(2, 9);
        wait_payload("reset", 90);
        @(posedge clk_i);
        #2;
        rst_ni   = 1'b0;
        src_rx_i = '0;
        for (int i = 0; i < N_SRC; i++) gen_q[i].delete();
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (3) drive_cycle(100, 100);

        // Traffic after reset.
        for (int it = 0; it < 400; it++) begin
            if (pending() < 10) add_packet($urandom_range(N_SRC - 1), $urandom_range(0, 5));
            release_i = ($urandom_range(99) < 90);
            drive_cycle(80, 70);
        end
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
